// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage: default widths and shifter opcodes.
package shift_issue_stage_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned RA_W_DEF   = 3;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

endpackage

// File: rtl/shift_issue_stage_fwd_mux.sv
// Three-way operand forwarding select: EX/MEM result, then MEM/WB result, then register file.
module shift_issue_stage_fwd_mux
  import shift_issue_stage_pkg::*;
#(
  parameter int unsigned W    = DATA_W_DEF,
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] addr,
  input  logic [W-1:0]    rf_data,
  input  logic            exmem_wr,
  input  logic            exmem_is_load,
  input  logic [RA_W-1:0] exmem_dst,
  input  logic [W-1:0]    exmem_data,
  input  logic            memwb_wr,
  input  logic [RA_W-1:0] memwb_dst,
  input  logic [W-1:0]    memwb_data,
  output logic [W-1:0]    data
);

  // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet and is never forwarded.
  always_comb begin
    data = rf_data;
    if (exmem_wr && !exmem_is_load && (exmem_dst == addr)) begin
      data = exmem_data;
    end else if (memwb_wr && (memwb_dst == addr)) begin
      data = memwb_data;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// ID/EX register feeding the barrel shifter: forwarding, count select, load-use bubble,
// stall/flush handling and a saturating issue counter.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned RA_W   = RA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        id_op,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              id_use_imm,
  input  logic [CNT_W-1:0]  id_imm,
  input  logic [RA_W-1:0]   id_dst,
  input  logic              exmem_wr,
  input  logic              exmem_is_load,
  input  logic [RA_W-1:0]   exmem_dst,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [RA_W-1:0]   memwb_dst,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              stall,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              sh_valid,
  output logic [DATA_W-1:0] sh_in,
  output logic [CNT_W-1:0]  sh_cnt,
  output logic [1:0]        sh_op,
  output logic [RA_W-1:0]   sh_dst,
  output logic [15:0]       issued_cnt
);

  logic [DATA_W-1:0] fwd_rs;
  logic [CNT_W-1:0]  fwd_rt;
  logic [CNT_W-1:0]  cnt_sel;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [RA_W-1:0]   dst_q, dst_d;
  logic [15:0]       issued_q, issued_d;

  shift_issue_stage_fwd_mux #(
    .W    (DATA_W),
    .RA_W (RA_W)
  ) u_fwd_rs (
    .addr          (id_rs_addr),
    .rf_data       (id_rs_data),
    .exmem_wr      (exmem_wr),
    .exmem_is_load (exmem_is_load),
    .exmem_dst     (exmem_dst),
    .exmem_data    (exmem_data),
    .memwb_wr      (memwb_wr),
    .memwb_dst     (memwb_dst),
    .memwb_data    (memwb_data),
    .data          (fwd_rs)
  );

  // Only the low count bits of rt ever reach the shifter, so forward just those.
  shift_issue_stage_fwd_mux #(
    .W    (CNT_W),
    .RA_W (RA_W)
  ) u_fwd_rt (
    .addr          (id_rt_addr),
    .rf_data       (id_rt_data[CNT_W-1:0]),
    .exmem_wr      (exmem_wr),
    .exmem_is_load (exmem_is_load),
    .exmem_dst     (exmem_dst),
    .exmem_data    (exmem_data[CNT_W-1:0]),
    .memwb_wr      (memwb_wr),
    .memwb_dst     (memwb_dst),
    .memwb_data    (memwb_data[CNT_W-1:0]),
    .data          (fwd_rt)
  );

  // Load-use detection and count source select.
  always_comb begin
    hazard_stall = id_valid && exmem_wr && exmem_is_load &&
                   ((exmem_dst == id_rs_addr) || (!id_use_imm && (exmem_dst == id_rt_addr)));
    cnt_sel      = id_use_imm ? id_imm : fwd_rt;
  end

  // Next state in priority order: flush, stall, load-use bubble, capture.
  always_comb begin
    valid_d  = valid_q;
    in_d     = in_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dst_d    = dst_q;
    issued_d = issued_q;
    if (flush || (!stall && hazard_stall)) begin
      valid_d = 1'b0;
      in_d    = '0;
      cnt_d   = '0;
      op_d    = '0;
      dst_d   = '0;
    end else if (!stall) begin
      valid_d = id_valid;
      in_d    = fwd_rs;
      cnt_d   = cnt_sel;
      op_d    = id_op;
      dst_d   = id_dst;
      if (id_valid && (issued_q != 16'hFFFF)) begin
        issued_d = issued_q + 16'd1;
      end
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      in_q     <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      issued_q <= '0;
    end else begin
      valid_q  <= valid_d;
      in_q     <= in_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      issued_q <= issued_d;
    end
  end

  assign sh_valid   = valid_q;
  assign sh_in      = in_q;
  assign sh_cnt     = cnt_q;
  assign sh_op      = op_q;
  assign sh_dst     = dst_q;
  assign issued_cnt = issued_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed scenarios plus randomized traffic
// against a behavioural model of the stage.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [1:0]  id_op;
  logic [2:0]  id_rs_addr;
  logic [15:0] id_rs_data;
  logic [2:0]  id_rt_addr;
  logic [15:0] id_rt_data;
  logic        id_use_imm;
  logic [3:0]  id_imm;
  logic [2:0]  id_dst;
  logic        exmem_wr;
  logic        exmem_is_load;
  logic [2:0]  exmem_dst;
  logic [15:0] exmem_data;
  logic        memwb_wr;
  logic [2:0]  memwb_dst;
  logic [15:0] memwb_data;
  logic        stall;
  logic        flush;
  logic        hazard_stall;
  logic        sh_valid;
  logic [15:0] sh_in;
  logic [3:0]  sh_cnt;
  logic [1:0]  sh_op;
  logic [2:0]  sh_dst;
  logic [15:0] issued_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the registered outputs.
  logic        m_valid;
  logic [15:0] m_in;
  logic [3:0]  m_cnt;
  logic [1:0]  m_op;
  logic [2:0]  m_dst;
  int          m_issued;

  shift_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_op         (id_op),
    .id_rs_addr    (id_rs_addr),
    .id_rs_data    (id_rs_data),
    .id_rt_addr    (id_rt_addr),
    .id_rt_data    (id_rt_data),
    .id_use_imm    (id_use_imm),
    .id_imm        (id_imm),
    .id_dst        (id_dst),
    .exmem_wr      (exmem_wr),
    .exmem_is_load (exmem_is_load),
    .exmem_dst     (exmem_dst),
    .exmem_data    (exmem_data),
    .memwb_wr      (memwb_wr),
    .memwb_dst     (memwb_dst),
    .memwb_data    (memwb_data),
    .stall         (stall),
    .flush         (flush),
    .hazard_stall  (hazard_stall),
    .sh_valid      (sh_valid),
    .sh_in         (sh_in),
    .sh_cnt        (sh_cnt),
    .sh_op         (sh_op),
    .sh_dst        (sh_dst),
    .issued_cnt    (issued_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_fwd(input logic [2:0] addr, input logic [15:0] rf);
    if (exmem_wr && !exmem_is_load && exmem_dst == addr) return exmem_data;
    if (memwb_wr && memwb_dst == addr) return memwb_data;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    if (!id_valid || !exmem_wr || !exmem_is_load) return 1'b0;
    if (exmem_dst == id_rs_addr) return 1'b1;
    if (!id_use_imm && exmem_dst == id_rt_addr) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_zero_fields();
    m_valid = 1'b0;
    m_in    = '0;
    m_cnt   = '0;
    m_op    = '0;
    m_dst   = '0;
  endtask

  // Advance the model by one rising edge using the inputs as they stand now.
  task automatic model_edge();
    logic [15:0] rtv;
    if (!rst_n) begin
      model_zero_fields();
      m_issued = 0;
    end else if (flush) begin
      model_zero_fields();
    end else if (stall) begin
      // hold
    end else if (ref_hazard()) begin
      model_zero_fields();
    end else begin
      rtv     = ref_fwd(id_rt_addr, id_rt_data);
      m_valid = id_valid;
      m_in    = ref_fwd(id_rs_addr, id_rs_data);
      m_cnt   = id_use_imm ? id_imm : rtv[3:0];
      m_op    = id_op;
      m_dst   = id_dst;
      if (id_valid && m_issued < 65535) m_issued++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_op = 0; id_rs_addr = 0; id_rs_data = 0; id_rt_addr = 0;
    id_rt_data = 0; id_use_imm = 1; id_imm = 0; id_dst = 0;
    exmem_wr = 0; exmem_is_load = 0; exmem_dst = 0; exmem_data = 0;
    memwb_wr = 0; memwb_dst = 0; memwb_data = 0; stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    model_zero_fields();
    m_issued = 0;
    #2;
    n_tests++;
    if ({sh_valid, sh_in, sh_cnt, sh_op, sh_dst, issued_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset: got v=%b in=%h cnt=%h op=%b dst=%h iss=%h, expected all zero",
               sh_valid, sh_in, sh_cnt, sh_op, sh_dst, issued_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_plain_issue();
    idle_inputs();
    id_valid = 1; id_rs_addr = 1; id_rs_data = 16'h8001; id_use_imm = 1; id_imm = 4'h1;
    id_op = 2'b00; id_dst = 3'd6;
    tick();
    idle_inputs();
    n_tests++;
    if (sh_valid !== 1'b1 || sh_in !== 16'h8001 || sh_cnt !== 4'h1 || sh_op !== 2'b00 ||
        sh_dst !== 3'd6) begin
      n_fail++;
      $display("FAIL plain_issue: got v=%b in=%h cnt=%h op=%b dst=%h, expected 1 8001 1 00 6",
               sh_valid, sh_in, sh_cnt, sh_op, sh_dst);
    end
    n_tests++;
    if (issued_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL plain_issue_count: got %h expected 0001", issued_cnt);
    end
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    id_valid = 1; id_rs_addr = 3; id_rs_data = 16'h0BAD; id_op = 2'b01;
    exmem_wr = 1; exmem_dst = 3; exmem_data = 16'hABCD;
    memwb_wr = 1; memwb_dst = 3; memwb_data = 16'h1234;
    tick();
    n_tests++;
    if (sh_in !== 16'hABCD) begin
      n_fail++;
      $display("FAIL fwd_exmem: got %h expected abcd", sh_in);
    end
    exmem_wr = 0;
    tick();
    n_tests++;
    if (sh_in !== 16'h1234) begin
      n_fail++;
      $display("FAIL fwd_memwb: got %h expected 1234", sh_in);
    end
    memwb_wr = 0;
    tick();
    n_tests++;
    if (sh_in !== 16'h0BAD || sh_op !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_none: got in=%h op=%b expected 0bad 01", sh_in, sh_op);
    end
  endtask

  task automatic test_reg_count();
    idle_inputs();
    id_valid = 1; id_use_imm = 0; id_imm = 4'hC; id_rt_addr = 5; id_rt_data = 16'h0002;
    memwb_wr = 1; memwb_dst = 5; memwb_data = 16'hFFF7;
    tick();
    n_tests++;
    if (sh_cnt !== 4'h7) begin
      n_fail++;
      $display("FAIL reg_count: got %h expected 7", sh_cnt);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    id_valid = 1; id_rs_addr = 2; id_rs_data = 16'h1111; id_use_imm = 1; id_imm = 4'h3;
    exmem_wr = 1; exmem_is_load = 1; exmem_dst = 2; exmem_data = 16'hDEAD;
    #1;
    n_tests++;
    if (hazard_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_hazard: got %b expected 1", hazard_stall);
    end
    tick();
    n_tests++;
    if (sh_valid !== 1'b0 || sh_in !== 16'h0000) begin
      n_fail++;
      $display("FAIL load_use_bubble: got v=%b in=%h expected 0 0000", sh_valid, sh_in);
    end
    exmem_wr = 0; exmem_is_load = 0;
    memwb_wr = 1; memwb_dst = 2; memwb_data = 16'h5A5A;
    #1;
    n_tests++;
    if (hazard_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_clear: got %b expected 0", hazard_stall);
    end
    tick();
    n_tests++;
    if (sh_valid !== 1'b1 || sh_in !== 16'h5A5A || sh_cnt !== 4'h3) begin
      n_fail++;
      $display("FAIL load_use_issue: got v=%b in=%h cnt=%h expected 1 5a5a 3",
               sh_valid, sh_in, sh_cnt);
    end
  endtask

  task automatic test_stall_flush();
    int held;
    idle_inputs();
    id_valid = 1; id_rs_addr = 4; id_rs_data = 16'h00F0; id_imm = 4'h2; id_op = 2'b11;
    tick();
    n_tests++;
    if (sh_in !== 16'h00F0 || sh_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_capture: got v=%b in=%h expected 1 00f0", sh_valid, sh_in);
    end
    held = m_issued;
    stall = 1; id_rs_data = 16'hFFFF; id_imm = 4'h9; id_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (sh_valid !== 1'b1 || sh_in !== 16'h00F0 || sh_cnt !== 4'h2 || sh_op !== 2'b11 ||
          issued_cnt !== 16'(held)) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b in=%h cnt=%h op=%b iss=%h expected 1 00f0 2 11 %h",
                 sh_valid, sh_in, sh_cnt, sh_op, issued_cnt, 16'(held));
      end
    end
    flush = 1;
    tick();
    n_tests++;
    if (sh_valid !== 1'b0 || sh_in !== 16'h0000 || issued_cnt !== 16'(held)) begin
      n_fail++;
      $display("FAIL flush_over_stall: got v=%b in=%h iss=%h expected 0 0000 %h",
               sh_valid, sh_in, issued_cnt, 16'(held));
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_op         = 2'($urandom);
      id_rs_addr    = 3'($urandom);
      id_rs_data    = 16'($urandom);
      id_rt_addr    = 3'($urandom);
      id_rt_data    = 16'($urandom);
      id_use_imm    = 1'($urandom);
      id_imm        = 4'($urandom);
      id_dst        = 3'($urandom);
      exmem_wr      = 1'($urandom);
      exmem_is_load = ($urandom_range(0, 3) == 0);
      exmem_dst     = 3'($urandom);
      exmem_data    = 16'($urandom);
      memwb_wr      = 1'($urandom);
      memwb_dst     = 3'($urandom);
      memwb_data    = 16'($urandom);
      stall         = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      #1;
      n_tests++;
      if (hazard_stall !== ref_hazard()) begin
        n_fail++;
        $display("FAIL rand_hazard[%0d]: got %b expected %b", i, hazard_stall, ref_hazard());
      end
      tick();
      n_tests++;
      if (sh_valid !== m_valid || sh_in !== m_in || sh_cnt !== m_cnt || sh_op !== m_op ||
          sh_dst !== m_dst || issued_cnt !== 16'(m_issued)) begin
        n_fail++;
        $display("FAIL rand_outputs[%0d]: got v=%b in=%h cnt=%h op=%b dst=%h iss=%h expected v=%b in=%h cnt=%h op=%b dst=%h iss=%h",
                 i, sh_valid, sh_in, sh_cnt, sh_op, sh_dst, issued_cnt,
                 m_valid, m_in, m_cnt, m_op, m_dst, 16'(m_issued));
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate_and_reset();
    idle_inputs();
    id_valid = 1; id_rs_data = 16'h0F0F;
    for (int i = 0; i < 70000 && m_issued < 65535; i++) tick();
    n_tests++;
    if (issued_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate_reach: got %h expected ffff", issued_cnt);
    end
    tick();
    n_tests++;
    if (issued_cnt !== 16'hFFFF || sh_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate_hold: got iss=%h v=%b expected ffff 1", issued_cnt, sh_valid);
    end
    stall = 1;
    #3;
    rst_n = 0;
    model_zero_fields();
    m_issued = 0;
    #1;
    n_tests++;
    if ({sh_valid, sh_in, sh_cnt, sh_op, sh_dst, issued_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b in=%h cnt=%h op=%b dst=%h iss=%h, expected all zero",
               sh_valid, sh_in, sh_cnt, sh_op, sh_dst, issued_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    stall = 0;
    tick();
    n_tests++;
    if (issued_cnt !== 16'd1 || sh_valid !== 1'b1 || sh_in !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL reset_resume: got iss=%h v=%b in=%h expected 0001 1 0f0f",
               issued_cnt, sh_valid, sh_in);
    end
  endtask

  initial begin
    test_reset();
    test_plain_issue();
    test_forward_priority();
    test_reg_count();
    test_load_use();
    test_stall_flush();
    test_random();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the execute-stage barrel shifter.
- Captures decoded shift instructions and resolves operand forwarding from EX/MEM and MEM/WB.
- Selects the shift count from an immediate or a register, and detects load-use hazards.
- Presents registered In/Cnt/Op operands to the shifter one cycle later, with valid, stall and flush handling.

Parameters:
- DATA_W, 16, datapath width; shifter operand width.
- CNT_W, 4, shift-count width; the count is taken from the low CNT_W bits of its source.
- RA_W, 3, register address width (8 architectural registers, none hardwired).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode presents a shift instruction this cycle.
- id_op  in  2  shift opcode: 00 rotate-left, 01 shift-left logical, 10 rotate-right, 11 shift-right logical.
- id_rs_addr  in  RA_W  source register holding the value to shift.
- id_rs_data  in  DATA_W  register-file read of rs.
- id_rt_addr  in  RA_W  count register.
- id_rt_data  in  DATA_W  register-file read of rt.
- id_use_imm  in  1  1: count = id_imm; 0: count = forwarded rt[CNT_W-1:0].
- id_imm  in  CNT_W  immediate shift count.
- id_dst  in  RA_W  destination register.
- exmem_wr  in  1  EX/MEM instruction writes a register.
- exmem_is_load  in  1  EX/MEM instruction is a load (data not yet available).
- exmem_dst  in  RA_W  EX/MEM destination register.
- exmem_data  in  DATA_W  EX/MEM result.
- memwb_wr  in  1  MEM/WB instruction writes a register.
- memwb_dst  in  RA_W  MEM/WB destination register.
- memwb_data  in  DATA_W  MEM/WB result.
- stall  in  1  downstream stall; stage holds its state.
- flush  in  1  branch flush; stage empties.
- hazard_stall  out  1  combinational load-use stall request to IF/ID.
- sh_valid  out  1  registered: operands below are a live instruction.
- sh_in  out  DATA_W  registered shifter In.
- sh_cnt  out  CNT_W  registered shifter Cnt.
- sh_op  out  2  registered shifter Op.
- sh_dst  out  RA_W  registered destination.
- issued_cnt  out  16  saturating count of issued instructions.

Behaviour:
- Reset (rst_n=0, async): all registered outputs are 0 (sh_valid, sh_in, sh_cnt, sh_op, sh_dst, issued_cnt). hazard_stall is combinational and is not reset-gated.
- Forwarding, rs value:
  - exmem_wr && !exmem_is_load && exmem_dst==id_rs_addr -> exmem_data;
  - else memwb_wr && memwb_dst==id_rs_addr -> memwb_data;
  - else id_rs_data.
  - EX/MEM always has priority over MEM/WB.
- Forwarding, rt value: same rules applied to id_rt_addr. Only used when id_use_imm=0.
- Count: id_use_imm ? id_imm : fwd_rt[CNT_W-1:0]. Upper rt bits are ignored.
- hazard_stall = id_valid && exmem_wr && exmem_is_load && (exmem_dst==id_rs_addr || (!id_use_imm && exmem_dst==id_rt_addr)).
- Per-edge priority, highest first:
  1. flush: sh_valid <= 0; sh_in/sh_cnt/sh_op/sh_dst <= 0.
  2. stall: all registers hold, including issued_cnt.
  3. hazard_stall: insert bubble (sh_valid <= 0, data fields <= 0). IF/ID holds the instruction, which re-presents next cycle.
  4. Otherwise capture: sh_valid <= id_valid, data fields <= forwarded/selected values. Fields are captured even when id_valid=0.
- Latency: exactly 1 cycle from ID to the sh_* outputs.
- issued_cnt increments on each capture with id_valid=1 and saturates at 16'hFFFF. It does not wrap.
- flush and stall both asserted: flush wins.
- Reset mid-stall: outputs go to 0 immediately. Normal operation resumes on the first edge after rst_n rises.

Decomposition:
- Shared pipeline package holds:
  - shift opcode constants OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRL=2'b11;
  - DATA_W/CNT_W/RA_W defaults.
- One sub-module, fwd_mux: the 3-way forwarding select, instantiated twice (rs, rt). The rest is flat.

Test Plan:
- Plain issue: id_valid=1, rs_data=16'h8001, use_imm=1, imm=4'h1, op=00, no forwarding. Next cycle sh_valid=1, sh_in=16'h8001, sh_cnt=1, sh_op=00, issued_cnt=1.
- Forward priority: rs_addr=3, exmem_wr=1/dst=3/data=16'hABCD, memwb_wr=1/dst=3/data=16'h1234 -> sh_in=16'hABCD. With exmem_wr=0 -> sh_in=16'h1234.
- Register count: use_imm=0, rt_addr=5, memwb dst=5, data=16'hFFF7 -> sh_cnt=4'h7.
- Load-use: exmem_is_load=1, exmem_wr=1, dst=rs_addr -> hazard_stall=1 the same cycle, next sh_valid=0. Once the load leaves EX/MEM, the instruction issues with the MEM/WB-forwarded value.
- Stall/flush: capture 16'h00F0, then stall=1 for 3 cycles -> outputs hold. Then flush=1 with stall=1 -> sh_valid=0, sh_in=0.
- Async reset with issued_cnt=16'hFFFF: assert rst_n=0 mid-cycle -> all outputs 0 before the next edge. Separately, preload 16'hFFFF and issue once -> stays 16'hFFFF.
